// File: rtl/serial_word_collector.sv
// rtl/serial_word_collector.sv - assembles a serial bit stream into WIDTH-bit words offered over valid/ready; optional PARITY_CHECK_EN adds an even-parity bit per frame
module serial_word_collector #(
  parameter int WIDTH     = 7,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             out_ready,
  output logic [7:0]       word_count,
  output logic             parity_err
);

`ifdef PARITY_CHECK_EN
  // The last serial bit of each frame is the parity bit, not data.
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int               CNT_W = $clog2(FRAME);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_word;
  logic             r_word_valid;
  logic [7:0]       r_word_count;

  logic             w_last;
  logic             w_stall;
  logic             w_accept;
  logic             w_complete;
  logic             w_consume;
  logic             w_shift_en;
  logic [WIDTH-1:0] w_shift_next;
  logic [WIDTH-1:0] w_word_next;

  // Handshake decode: stall only when the final bit would overwrite an unconsumed word.
  always_comb begin
    w_last     = (r_cnt == LAST);
    w_stall    = w_last && r_word_valid && !out_ready;
    w_accept   = bit_valid && !w_stall;
    w_complete = w_accept && w_last && !flush;
    w_consume  = r_word_valid && out_ready;
    w_shift_en = w_accept && !flush && !w_last;
  end

  assign bit_ready = !w_stall;

  // Next shift-register value with the incoming bit inserted at the configured end.
  always_comb begin
    w_shift_next = r_shift;
    if (MSB_FIRST != 0) begin
      w_shift_next = {r_shift[WIDTH-2:0], bit_in};
    end else begin
      w_shift_next = {bit_in, r_shift[WIDTH-1:1]};
    end
  end

  // Finished word: with parity the data is already in the shift register, otherwise
  // the final accepted bit still has to be merged in.
  always_comb begin
`ifdef PARITY_CHECK_EN
    w_word_next = r_shift;
`else
    w_word_next = w_shift_next;
`endif
  end

  // Bit counter and shift register; flush and completion both restart the frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (flush) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (w_complete) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (w_shift_en) begin
      r_cnt   <= r_cnt + CNT_W'(1);
      r_shift <= w_shift_next;
    end
  end

  // Output holding register; it keeps its value after consumption.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else if (w_complete) begin
      r_word       <= w_word_next;
      r_word_valid <= 1'b1;
    end else if (w_consume) begin
      r_word_valid <= 1'b0;
    end
  end

  // Delivered-word counter, wraps naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word_count <= '0;
    end else if (w_consume) begin
      r_word_count <= r_word_count + 8'd1;
    end
  end

`ifdef PARITY_CHECK_EN
  logic r_parity_err;

  // Even-parity check over data plus parity bit, loaded alongside the word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_parity_err <= 1'b0;
    end else if (w_complete) begin
      r_parity_err <= (^r_shift) ^ bit_in;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign word_out   = r_word;
  assign word_valid = r_word_valid;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_serial_word_collector.sv
// tb/tb_serial_word_collector.sv - directed self-checking bench for serial_word_collector
module tb_serial_word_collector;

`ifdef PARITY_CHECK_EN
  localparam int FRAME = 8;
`else
  localparam int FRAME = 7;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;

  logic       m_bit_ready, l_bit_ready;
  logic [6:0] m_word_out, l_word_out;
  logic       m_word_valid, l_word_valid;
  logic [7:0] m_word_count, l_word_count;
  logic       m_parity_err, l_parity_err;

  int n_vec = 0;
  int n_err = 0;

  serial_word_collector #(.WIDTH(7), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(m_bit_ready), .flush(flush), .word_out(m_word_out),
    .word_valid(m_word_valid), .out_ready(out_ready),
    .word_count(m_word_count), .parity_err(m_parity_err)
  );

  serial_word_collector #(.WIDTH(7), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(l_bit_ready), .flush(flush), .word_out(l_word_out),
    .word_valid(l_word_valid), .out_ready(out_ready),
    .word_count(l_word_count), .parity_err(l_parity_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    bit_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bit_in = b;
    bit_valid = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [6:0] d, input logic par);
    for (int i = 6; i >= 0; i--) send_bit(d[i]);
`ifdef PARITY_CHECK_EN
    send_bit(par);
`endif
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++; if (m_word_out !== 7'd0) begin n_err++; $display("FAIL rst_word_out: got %b expected %b", m_word_out, 7'd0); end
    n_vec++; if (m_word_valid !== 1'b0) begin n_err++; $display("FAIL rst_word_valid: got %b expected 0", m_word_valid); end
    n_vec++; if (m_word_count !== 8'd0) begin n_err++; $display("FAIL rst_word_count: got %0d expected 0", m_word_count); end
    n_vec++; if (m_parity_err !== 1'b0) begin n_err++; $display("FAIL rst_parity_err: got %b expected 0", m_parity_err); end
    n_vec++; if (m_bit_ready !== 1'b1) begin n_err++; $display("FAIL rst_bit_ready: got %b expected 1", m_bit_ready); end
  endtask

  task automatic test_msb_first();
    logic [6:0] a = 7'b1011001;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 6; i >= 1; i--) send_bit(a[i]);
`ifdef PARITY_CHECK_EN
    send_bit(a[0]);
`endif
    n_vec++; if (m_word_valid !== 1'b0) begin n_err++; $display("FAIL msb_early_valid: got %b expected 0", m_word_valid); end
`ifdef PARITY_CHECK_EN
    send_bit(1'b0);
`else
    send_bit(a[0]);
`endif
    n_vec++; if (m_word_valid !== 1'b1) begin n_err++; $display("FAIL msb_word_valid: got %b expected 1", m_word_valid); end
    n_vec++; if (m_word_out !== 7'b1011001) begin n_err++; $display("FAIL msb_word_out: got %b expected %b", m_word_out, 7'b1011001); end
    n_vec++; if (m_word_count !== 8'd0) begin n_err++; $display("FAIL msb_count_before: got %0d expected 0", m_word_count); end
    @(negedge clk);
    n_vec++; if (m_word_count !== 8'd1) begin n_err++; $display("FAIL msb_count_after: got %0d expected 1", m_word_count); end
    n_vec++; if (m_word_valid !== 1'b0) begin n_err++; $display("FAIL msb_valid_drop: got %b expected 0", m_word_valid); end
    n_vec++; if (m_word_out !== 7'b1011001) begin n_err++; $display("FAIL msb_word_hold: got %b expected %b", m_word_out, 7'b1011001); end
    out_ready = 1'b0;
  endtask

  task automatic test_lsb_first();
    apply_reset();
    out_ready = 1'b1;
    send_frame(7'b1011001, 1'b0);
    n_vec++; if (l_word_valid !== 1'b1) begin n_err++; $display("FAIL lsb_word_valid: got %b expected 1", l_word_valid); end
    n_vec++; if (l_word_out !== 7'b1001101) begin n_err++; $display("FAIL lsb_word_out: got %b expected %b", l_word_out, 7'b1001101); end
    @(negedge clk);
    n_vec++; if (l_word_count !== 8'd1) begin n_err++; $display("FAIL lsb_count: got %0d expected 1", l_word_count); end
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [6:0] b = 7'b0110110;
    logic       last_b;
    apply_reset();
    out_ready = 1'b0;
    send_frame(7'b1011001, 1'b0);
    n_vec++; if (m_word_out !== 7'b1011001) begin n_err++; $display("FAIL stall_a_loaded: got %b expected %b", m_word_out, 7'b1011001); end
`ifdef PARITY_CHECK_EN
    for (int i = 6; i >= 0; i--) send_bit(b[i]);
    last_b = 1'b0;
`else
    for (int i = 6; i >= 1; i--) send_bit(b[i]);
    last_b = b[0];
`endif
    bit_in = last_b;
    bit_valid = 1'b1;
    #1;
    n_vec++; if (m_bit_ready !== 1'b0) begin n_err++; $display("FAIL stall_bit_ready: got %b expected 0", m_bit_ready); end
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (m_word_out !== 7'b1011001) begin n_err++; $display("FAIL stall_word_hold: got %b expected %b", m_word_out, 7'b1011001); end
    n_vec++; if (m_word_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid_hold: got %b expected 1", m_word_valid); end
    n_vec++; if (m_word_count !== 8'd0) begin n_err++; $display("FAIL stall_count_hold: got %0d expected 0", m_word_count); end
    out_ready = 1'b1;
    #1;
    n_vec++; if (m_bit_ready !== 1'b1) begin n_err++; $display("FAIL stall_ready_comb: got %b expected 1", m_bit_ready); end
    @(negedge clk);
    bit_valid = 1'b0;
    out_ready = 1'b0;
    n_vec++; if (m_word_out !== 7'b0110110) begin n_err++; $display("FAIL stall_word_b: got %b expected %b", m_word_out, 7'b0110110); end
    n_vec++; if (m_word_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid_b: got %b expected 1", m_word_valid); end
    n_vec++; if (m_word_count !== 8'd1) begin n_err++; $display("FAIL stall_count_b: got %0d expected 1", m_word_count); end
    @(negedge clk);
    n_vec++; if (m_word_valid !== 1'b1) begin n_err++; $display("FAIL stall_b_held: got %b expected 1", m_word_valid); end
  endtask

  task automatic test_flush();
    apply_reset();
    out_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    bit_in = 1'b0;
    bit_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bit_valid = 1'b0;
    send_frame(7'b1111111, 1'b1);
    n_vec++; if (m_word_valid !== 1'b1) begin n_err++; $display("FAIL flush_valid: got %b expected 1", m_word_valid); end
    n_vec++; if (m_word_out !== 7'h7F) begin n_err++; $display("FAIL flush_word_out: got %b expected %b", m_word_out, 7'h7F); end
    @(negedge clk);
    n_vec++; if (m_word_count !== 8'd1) begin n_err++; $display("FAIL flush_count: got %0d expected 1", m_word_count); end
    for (int i = 0; i < FRAME - 1; i++) send_bit(1'b0);
    bit_in = 1'b0;
    bit_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bit_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (m_word_valid !== 1'b0) begin n_err++; $display("FAIL flush_prio_valid: got %b expected 0", m_word_valid); end
    n_vec++; if (m_word_out !== 7'h7F) begin n_err++; $display("FAIL flush_prio_word: got %b expected %b", m_word_out, 7'h7F); end
    n_vec++; if (m_word_count !== 8'd1) begin n_err++; $display("FAIL flush_prio_count: got %0d expected 1", m_word_count); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_word();
    apply_reset();
    out_ready = 1'b1;
    send_frame(7'b1011001, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    send_frame(7'b1011001, 1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    n_vec++; if (m_word_count !== 8'd1) begin n_err++; $display("FAIL rmid_count_pre: got %0d expected 1", m_word_count); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++; if (m_word_out !== 7'd0) begin n_err++; $display("FAIL rmid_word_out: got %b expected %b", m_word_out, 7'd0); end
    n_vec++; if (m_word_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b expected 0", m_word_valid); end
    n_vec++; if (m_word_count !== 8'd0) begin n_err++; $display("FAIL rmid_count: got %0d expected 0", m_word_count); end
    n_vec++; if (m_bit_ready !== 1'b1) begin n_err++; $display("FAIL rmid_bit_ready: got %b expected 1", m_bit_ready); end
    send_frame(7'b1100101, 1'b0);
    n_vec++; if (m_word_out !== 7'b1100101) begin n_err++; $display("FAIL rmid_clean_word: got %b expected %b", m_word_out, 7'b1100101); end
    n_vec++; if (m_word_valid !== 1'b1) begin n_err++; $display("FAIL rmid_clean_valid: got %b expected 1", m_word_valid); end
  endtask

  task automatic test_wrap();
    logic [7:0] v;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      send_frame(v[6:0], ^v[6:0]);
    end
    n_vec++; if (m_word_count !== 8'd255) begin n_err++; $display("FAIL wrap_count_255: got %0d expected 255", m_word_count); end
    n_vec++; if (m_word_out !== 7'h7F) begin n_err++; $display("FAIL wrap_last_word: got %b expected %b", m_word_out, 7'h7F); end
    @(negedge clk);
    n_vec++; if (m_word_count !== 8'd0) begin n_err++; $display("FAIL wrap_count_0: got %0d expected 0", m_word_count); end
    n_vec++; if (m_word_valid !== 1'b0) begin n_err++; $display("FAIL wrap_valid: got %b expected 0", m_word_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_parity();
    apply_reset();
    out_ready = 1'b1;
    send_frame(7'b1011001, 1'b1);
`ifdef PARITY_CHECK_EN
    n_vec++; if (m_parity_err !== 1'b1) begin n_err++; $display("FAIL par_err_set: got %b expected 1", m_parity_err); end
`else
    n_vec++; if (m_parity_err !== 1'b0) begin n_err++; $display("FAIL par_tied_low: got %b expected 0", m_parity_err); end
`endif
    n_vec++; if (m_word_out !== 7'b1011001) begin n_err++; $display("FAIL par_word_out: got %b expected %b", m_word_out, 7'b1011001); end
    send_frame(7'b1011001, 1'b0);
    n_vec++; if (m_parity_err !== 1'b0) begin n_err++; $display("FAIL par_err_clear: got %b expected 0", m_parity_err); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_stall();
    test_flush();
    test_reset_mid_word();
    test_wrap();
    test_parity();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
